// File: rtl/vga_axil_regfile.sv
// AXI4-Lite register file: NUM_REGS x DATA_W registers with byte strobes,
// independent write/read state machines and a flat view of every register.
module vga_axil_regfile #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] regs
);
  localparam int         BYTES  = DATA_W / 8;
  localparam int         OFF_W  = $clog2(BYTES);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              live;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  wstrb_q;
  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data, rd_val;
  logic [BYTES-1:0]  wr_strb;

  function automatic logic [ADDR_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return a >> OFF_W;
  endfunction

  // live holds every ready low until the first clock edge after reset release
  assign awready = live && (w_state == W_IDLE) && !aw_held;
  assign wready  = live && (w_state == W_IDLE) && !w_held;
  assign arready = live && (r_state == R_IDLE);
  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_RESP);

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A latched half and an in-flight half combine into one commit on the same edge
  assign wr_idx  = to_idx(aw_held ? aw_addr_q : awaddr);
  assign wr_data = w_held ? wdata_q : wdata;
  assign wr_strb = w_held ? wstrb_q : wstrb;
  assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok   = int'(wr_idx) < NUM_REGS;

  assign rd_idx  = to_idx(araddr);
  assign rd_ok   = int'(rd_idx) < NUM_REGS;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(rd_idx) == i) rd_val = mem[i];
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      live    <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp   <= OKAY;
      rresp   <= OKAY;
      rdata   <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp   <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
      if (ar_hs) begin
        rdata <= rd_ok ? rd_val : '0;
        rresp <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (int'(wr_idx) == i)
          for (int b = 0; b < BYTES; b++)
            if (wr_strb[b]) mem[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule
